// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the writeback commit controller:
// CSR op encodings, CSR numbers, commit kinds and the WB stage register.
package wb_commit_pkg;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RD   = 2'b01,
        CSR_OP_WR   = 2'b10,
        CSR_OP_XCHG = 2'b11
    } csr_op_t;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;

    localparam logic [5:0] ECODE_INT = 6'h00;

    localparam int unsigned DRAIN_W = 4;

    typedef enum logic [2:0] {
        CK_NONE,
        CK_INT,
        CK_EX,
        CK_ERTN,
        CK_NORMAL
    } commit_kind_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        csr_op_t     csr_op;
        logic [13:0] csr_num;
        logic [31:0] rj_value;
        logic [31:0] rd_value;
        logic        ertn;
        logic        ex;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } wb_stage_t;

endpackage

// File: rtl/wb_commit_ctrl.sv
// Writeback-stage commit controller: registers the MEM->WB instruction, drives
// the CSR port, commits exceptions/ertn as a one-cycle flush, and counts retirements.
module wb_commit_ctrl
    import wb_commit_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [1:0]  in_csr_op,
    input  logic [13:0] in_csr_num,
    input  logic [31:0] in_rj_value,
    input  logic [31:0] in_rd_value,
    input  logic        in_ertn,
    input  logic        in_ex,
    input  logic [5:0]  in_ecode,
    input  logic [8:0]  in_esubcode,
    input  logic        in_rf_we,
    input  logic [4:0]  in_rf_waddr,
    input  logic [31:0] in_rf_wdata,
    output logic [13:0] csr_rnum,
    output logic [13:0] csr_wnum,
    output logic        csr_we,
    output logic [31:0] csr_wvalue,
    output logic [31:0] csr_wmask,
    input  logic [31:0] csr_rvalue,
    output logic [31:0] wb_pc,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic        ertn_flush,
    input  logic [31:0] ex_entry,
    input  logic        has_int,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush,
    output logic [31:0] flush_target,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_FULL,
        S_DRAIN
    } state_t;

    state_t               state;
    wb_stage_t            stage;
    logic [DRAIN_W-1:0]   drain_cnt;
    commit_kind_t         kind;
    logic                 full;
    logic                 xfer;

    assign full = (state == S_FULL) && stage.valid;
    assign xfer = in_valid && in_ready;

    // The reset cycle must not commit anything, so reset gates the kind directly.
    always_comb begin
        kind = CK_NONE;
        if (full && !reset) begin
            if (has_int)
                kind = CK_INT;
            else if (stage.ex)
                kind = CK_EX;
            else if (stage.ertn)
                kind = CK_ERTN;
            else
                kind = CK_NORMAL;
        end
    end

    always_comb begin
        csr_rnum     = stage.csr_num;
        csr_wnum     = stage.csr_num;
        csr_we       = 1'b0;
        csr_wvalue   = '0;
        csr_wmask    = '0;
        wb_pc        = '0;
        wb_ex        = 1'b0;
        wb_ecode     = '0;
        wb_esubcode  = '0;
        ertn_flush   = 1'b0;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        flush        = 1'b0;
        flush_target = '0;

        if (kind != CK_NONE)
            wb_pc = stage.pc;

        unique case (kind)
            CK_INT: begin
                wb_ex        = 1'b1;
                wb_ecode     = ECODE_INT;
                wb_esubcode  = '0;
                flush        = 1'b1;
                flush_target = ex_entry;
            end
            CK_EX: begin
                wb_ex        = 1'b1;
                wb_ecode     = stage.ecode;
                wb_esubcode  = stage.esubcode;
                flush        = 1'b1;
                flush_target = ex_entry;
            end
            CK_ERTN: begin
                // Return address comes back on the read port from ERA.
                ertn_flush   = 1'b1;
                csr_rnum     = CSR_ERA;
                flush        = 1'b1;
                flush_target = csr_rvalue;
            end
            CK_NORMAL: begin
                rf_we    = stage.rf_we;
                rf_waddr = stage.rf_waddr;
                rf_wdata = stage.rf_wdata;
                unique case (stage.csr_op)
                    CSR_OP_RD: begin
                        rf_wdata = csr_rvalue;
                    end
                    CSR_OP_WR: begin
                        csr_we     = 1'b1;
                        csr_wmask  = '1;
                        csr_wvalue = stage.rd_value;
                        rf_wdata   = csr_rvalue;
                    end
                    CSR_OP_XCHG: begin
                        csr_we     = 1'b1;
                        csr_wmask  = stage.rj_value;
                        csr_wvalue = stage.rd_value;
                        rf_wdata   = csr_rvalue;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_EMPTY;
            stage     <= '0;
            drain_cnt <= '0;
            in_ready  <= 1'b1;
            retired   <= '0;
        end else begin
            if (kind == CK_NORMAL)
                retired <= retired + 32'd1;

            unique case (state)
                S_DRAIN: begin
                    if (drain_cnt <= DRAIN_W'(1)) begin
                        state    <= S_EMPTY;
                        in_ready <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                    if (flush) begin
                        // Any transfer accepted this cycle is dropped with the flushed instruction.
                        state       <= S_DRAIN;
                        drain_cnt   <= DRAIN_W'(DRAIN_CYCLES);
                        stage.valid <= 1'b0;
                        in_ready    <= 1'b0;
                    end else if (xfer) begin
                        state          <= S_FULL;
                        stage.valid    <= 1'b1;
                        stage.pc       <= in_pc;
                        stage.csr_op   <= csr_op_t'(in_csr_op);
                        stage.csr_num  <= in_csr_num;
                        stage.rj_value <= in_rj_value;
                        stage.rd_value <= in_rd_value;
                        stage.ertn     <= in_ertn;
                        stage.ex       <= in_ex;
                        stage.ecode    <= in_ecode;
                        stage.esubcode <= in_esubcode;
                        stage.rf_we    <= in_rf_we;
                        stage.rf_waddr <= in_rf_waddr;
                        stage.rf_wdata <= in_rf_wdata;
                    end else begin
                        state       <= S_EMPTY;
                        stage.valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/wb_commit_ctrl.md
# wb_commit_ctrl

Writeback-stage commit controller for the LoongArch pipeline. It is the initiator side of the control/status-register interface: it registers the instruction leaving MEM and drives the CSR read/write port (number, write enable, value, mask). It raises the exception and `ertn` commit signals toward the CSR file and turns the returned `ex_entry` / ERA into a one-cycle pipeline flush with a redirect target. It also performs register-file writeback and keeps a retired-instruction counter.

## Interface
- `DRAIN_CYCLES`, 2, cycles `in_ready` stays low after a flush pulse (range 1..15)
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid` / `in_ready`  in/out  1/1  MEM→WB handshake; transfer when both are high
- `in_pc`  in  32  instruction PC
- `in_csr_op`  in  2  00 none, 01 csrrd, 10 csrwr, 11 csrxchg
- `in_csr_num`  in  14  CSR number
- `in_rj_value`  in  32  xchg write mask
- `in_rd_value`  in  32  CSR write value
- `in_ertn`  in  1  instruction is `ertn`
- `in_ex`, `in_ecode`, `in_esubcode`  in  1/6/9  exception detected upstream
- `in_rf_we`, `in_rf_waddr`, `in_rf_wdata`  in  1/5/32  GPR write request
- `csr_rnum`, `csr_wnum`  out  14/14  CSR read and write numbers
- `csr_we`, `csr_wvalue`, `csr_wmask`  out  1/32/32  CSR write port
- `csr_rvalue`  in  32  CSR read data, combinational from `csr_rnum`
- `wb_pc`, `wb_ex`, `wb_ecode`, `wb_esubcode`, `ertn_flush`  out  32/1/6/9/1  exception commit signals
- `ex_entry`  in  32  exception entry address
- `has_int`  in  1  pending enabled interrupt
- `rf_we`, `rf_waddr`, `rf_wdata`  out  1/5/32  GPR write
- `flush`, `flush_target`  out  1/32  pipeline kill and redirect PC
- `retired`  out  32  count of committed instructions that are not flushed

## Operation
- States: EMPTY, FULL, DRAIN. Reset → EMPTY, counter 0, stage valid 0.
- In EMPTY and FULL, `in_ready`=1; in DRAIN, `in_ready`=0. A transfer loads the stage register and goes to FULL. FULL with no transfer goes to EMPTY.
- An instruction in FULL commits in that cycle. Commit kinds, in priority order:
  - INT: `has_int`=1. Sets `wb_ex`=1, `wb_ecode`=0x00, `wb_esubcode`=0.
  - EX: stage `ex`=1. Sets `wb_ex`=1 with the stage ecode/esubcode.
  - ERTN: sets `ertn_flush`=1 and forces `csr_rnum`=0x006 (ERA).
  - NORMAL: anything else.
- Effects of INT/EX:
  - `flush`=1, `flush_target`=`ex_entry`.
  - `csr_we`=0, `rf_we`=0.
  - The incoming transfer that cycle is discarded. `in_ready` is still 1 that cycle; the stage valid is cleared.
  - Next state is DRAIN, with the down-counter loaded to DRAIN_CYCLES.
- Effects of ERTN: `flush`=1, `flush_target`=`csr_rvalue`; otherwise identical to INT/EX.
- Effects of NORMAL:
  - `csr_rnum`=`csr_num`.
  - csrrd: `rf_wdata`=`csr_rvalue`.
  - csrwr: `csr_we`=1, `csr_wmask`=0xFFFFFFFF, `csr_wvalue`=`rd_value`, `rf_wdata`=old `csr_rvalue`.
  - csrxchg: same as csrwr but `csr_wmask`=`rj_value`.
  - `rf_we`=stage `rf_we` and `rf_waddr` pass through.
  - `retired`+1, wrapping 0xFFFFFFFF→0.
- `wb_pc`=stage PC whenever FULL. All commit outputs are 0 when not FULL; `csr_wnum`=`csr_rnum`=stage `csr_num` then.
- DRAIN: the counter decrements each cycle; at 1 the next state is EMPTY. `in_valid` is ignored.
- `reset` in any state wins: EMPTY next cycle, and no commit outputs are asserted in the reset cycle.

## Timing
- Latency: commit occurs in the cycle after the transfer. Throughput is one instruction per cycle with no flushes.
- Commit outputs, `flush` and `flush_target` are combinational from the stage register plus `has_int`, `csr_rvalue` and `ex_entry`. The CSR file samples its write port and exception inputs at the same edge that retires the stage.
- `flush` is high for exactly one cycle per INT/EX/ERTN. `in_ready` is then 0 for exactly DRAIN_CYCLES cycles.
- All outputs are 0 out of reset except `in_ready`=1, `wb_pc`=0 and `retired`=0.

## Structure
- Shared package `wb_commit_pkg`:
  - CSR op encodings.
  - CSR number constants: ERA=0x006, CRMD=0x000, PRMD=0x001, ESTAT=0x005, EENTRY=0x00C.
  - ECODE_INT=0x00.
  - Commit-kind enum.
  - Stage-register struct.
- Single module; no sub-module. The CSR-op mux is small enough to inline.

## Test plan
- csrwr 0x00C with `rd_value`=0x1C008000 and `csr_rvalue`=0x1C000000 → commit cycle has `csr_we`=1, `csr_wmask`=0xFFFFFFFF, `csr_wvalue`=0x1C008000, `rf_wdata`=0x1C000000; `retired` becomes 1.
- csrxchg with `rj_value`=0x0000000F and `rd_value`=0xAAAAAAAA → `csr_wmask`=0x0000000F, `csr_wvalue`=0xAAAAAAAA, `rf_we` follows input.
- `in_ex`=1, ecode 0x0B, `ex_entry`=0x1C001000, with a back-to-back instruction → `wb_ex`=1, `flush`=1 for one cycle, target 0x1C001000, `rf_we`=0. The following instruction is dropped, `in_ready`=0 for 2 cycles, `retired` unchanged.
- `ertn` with ERA read value 0x1C000ABC → `csr_rnum`=0x006, `ertn_flush`=1, `flush_target`=0x1C000ABC.
- `has_int`=1 while a csrwr sits in FULL → `wb_ecode`=0x00, `csr_we`=0 (interrupt beats CSR write). A simultaneous `in_ex` with `in_ertn` yields EX.
- `reset` asserted during DRAIN with count 2 → next cycle EMPTY, `in_ready`=1, `retired`=0. `retired` preloaded via 2^32 commits (or forced) wraps to 0.
